// File: rtl/add_sub_arbiter_pkg.sv
// Shared definitions for the round-robin add/subtract arbiter.
package add_sub_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor_nbit.sv
// N-bit adder/subtractor: add_n=0 gives a+b, add_n=1 gives a+~b+1; cout is bit n of that sum.
module adder_subtractor_nbit #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         add_n,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n-1:0] b_eff;
    logic [n:0]   full;

    always_comb begin
        b_eff = b ^ {n{add_n}};
        full  = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, add_n};
        sum   = full[n-1:0];
        cout  = full[n];
    end

endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one adder/subtractor among REQS requesters.
// Optional signed-overflow output rsp_ovf is enabled by defining ADD_SUB_ARB_OVF_EN.
module add_sub_arbiter
    import add_sub_arbiter_pkg::*;
#(
    parameter int N    = 16,
    parameter int REQS = 4,
    parameter int IDW  = $clog2(REQS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQS-1:0]   req_valid,
    output logic [REQS-1:0]   req_ready,
    input  logic [REQS*N-1:0] req_a,
    input  logic [REQS*N-1:0] req_b,
    input  logic [REQS-1:0]   req_add_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
`ifdef ADD_SUB_ARB_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic              rsp_cout
);

    state_t         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic           op_sub_q, op_sub_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
`ifdef ADD_SUB_ARB_OVF_EN
    logic           rsp_ovf_q, rsp_ovf_d;
    logic [N-1:0]   op_b_eff;
`endif

    logic [N-1:0]   add_sum;
    logic           add_cout;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    int unsigned    cand;

    adder_subtractor_nbit #(.n(N)) u_addsub (
        .a     (op_a_q),
        .b     (op_b_q),
        .add_n (op_sub_q),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    // Search upward from the requester after the last winner, wrapping modulo REQS.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int k = 1; k <= REQS; k++) begin
            cand = (int'(last_grant_q) + k) % REQS;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sub_d     = op_sub_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        req_ready    = '0;
`ifdef ADD_SUB_ARB_OVF_EN
        rsp_ovf_d    = rsp_ovf_q;
        op_b_eff     = (op_sub_q == OP_SUB) ? ~op_b_q : op_b_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    op_a_d       = req_a[grant_id*N +: N];
                    op_b_d       = req_b[grant_id*N +: N];
                    op_sub_d     = req_add_n[grant_id];
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ST_CALC;
                end
            end
            ST_CALC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_sum_d   = add_sum;
                rsp_cout_d  = add_cout;
`ifdef ADD_SUB_ARB_OVF_EN
                rsp_ovf_d   = (op_a_q[N-1] == op_b_eff[N-1]) && (add_sum[N-1] != op_a_q[N-1]);
`endif
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset discards any in-flight op; the response registers clear to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(REQS - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
`ifdef ADD_SUB_ARB_OVF_EN
            rsp_ovf_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
`ifdef ADD_SUB_ARB_OVF_EN
            rsp_ovf_q    <= rsp_ovf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
        op_sub_q <= op_sub_d;
        op_id_q  <= op_id_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
`ifdef ADD_SUB_ARB_OVF_EN
    assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Scoreboard bench for add_sub_arbiter (N=16, REQS=4); checks rsp_ovf when ADD_SUB_ARB_OVF_EN is defined.
module tb_add_sub_arbiter;

    localparam int N    = 16;
    localparam int REQS = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [63:0]   req_a;
    logic [63:0]   req_b;
    logic [3:0]    req_add_n;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_sum;
    logic          rsp_cout;
`ifdef ADD_SUB_ARB_OVF_EN
    logic          rsp_ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    int   nresp = 0;
    bit   armed = 0;
    bit   busy  = 0;
    int   mlast = 3;
    rsp_t exp_q[$];
    int   seen_ids[$];

    add_sub_arbiter #(.N(N), .REQS(REQS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_add_n (req_add_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
`ifdef ADD_SUB_ARB_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rsp_t model(input int id, input logic [15:0] a, input logic [15:0] b, input logic sub);
        rsp_t r;
        r.id = 2'(id);
        if (!sub) begin
            {r.cout, r.sum} = {1'b0, a} + {1'b0, b};
            r.ovf = (a[15] == b[15]) && (r.sum[15] != a[15]);
        end else begin
            r.sum  = a - b;
            r.cout = (a >= b);
            r.ovf  = (a[15] != b[15]) && (r.sum[15] != a[15]);
        end
        return r;
    endfunction

    // Monitor: grant model, scoreboard push on accept, pop on response handshake.
    always begin
        logic [3:0] exp_ready;
        int         g;
        rsp_t       e;
        @(negedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            busy  = 0;
            mlast = 3;
        end else if (armed) begin
            exp_ready = 4'b0000;
            g = 0;
            if (!busy) begin
                for (int k = 1; k <= REQS; k++) begin
                    int idx;
                    idx = (mlast + k) % REQS;
                    if (exp_ready == 4'b0000 && req_valid[idx]) begin
                        exp_ready[idx] = 1'b1;
                        g = idx;
                    end
                end
            end
            check_val("grant", 32'(req_ready), 32'(exp_ready));
            if (exp_ready != 4'b0000) begin
                exp_q.push_back(model(g, req_a[g*N +: N], req_b[g*N +: N], req_add_n[g]));
                busy  = 1;
                mlast = g;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("sb_id", 32'(rsp_id), 32'(e.id));
                    check_val("sb_sum", 32'(rsp_sum), 32'(e.sum));
                    check_val("sb_cout", 32'(rsp_cout), 32'(e.cout));
`ifdef ADD_SUB_ARB_OVF_EN
                    check_val("sb_ovf", 32'(rsp_ovf), 32'(e.ovf));
`endif
                end
                seen_ids.push_back(int'(rsp_id));
                nresp++;
                busy = 0;
            end
        end
    end

    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        bit got;
        @(negedge clk);
        req_valid[idx]       = 1'b1;
        req_a[idx*N +: N]    = a;
        req_b[idx*N +: N]    = b;
        req_add_n[idx]       = sub;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[idx]) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check_val("op_timeout", 32'd0, 32'd1);
            req_valid[idx] = 1'b0;
            return;
        end
        check_val("op_ready", 32'(req_ready), 32'(4'b0001 << idx));
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        check_val("op_lat_calc", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_val("op_lat_resp", 32'(rsp_valid), 32'd1);
        check_val("op_id", 32'(rsp_id), 32'(idx));
        check_val("op_sum", 32'(rsp_sum), 32'(exp_sum));
        check_val("op_cout", 32'(rsp_cout), 32'(exp_cout));
`ifdef ADD_SUB_ARB_OVF_EN
        check_val("op_ovf", 32'(rsp_ovf), 32'(exp_ovf));
`else
        if (exp_ovf) ;
`endif
    endtask

    initial begin
        int          n0;
        logic [1:0]  bp_id;
        logic [15:0] bp_sum;
        logic        bp_cout;
        logic [31:0] fair_exp [5];
        bit          got;

        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_add_n = '0;
        repeat (3) @(negedge clk);
        armed = 1;
        #1;
        check_val("rst_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_id", 32'(rsp_id), 32'd0);
        check_val("rst_sum", 32'(rsp_sum), 32'd0);
        check_val("rst_cout", 32'(rsp_cout), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_op(2, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op(3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Fairness with every requester continuously valid.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < REQS; i++) begin
            req_a[i*N +: N] = 16'($urandom);
            req_b[i*N +: N] = 16'($urandom);
            req_add_n[i]    = 1'($urandom);
        end
        seen_ids.delete();
        n0 = nresp;
        req_valid = 4'b1111;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (nresp - n0 >= 5) break;
        end
        req_valid = 4'b0000;
        fair_exp = '{0, 1, 2, 3, 0};
        check_val("fair_count", 32'(seen_ids.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < seen_ids.size(); i++)
            check_val($sformatf("fair_id%0d", i), 32'(seen_ids[i]), fair_exp[i]);
        repeat (4) @(negedge clk);

        // Backpressure: hold the response while other requesters wait.
        rsp_ready = 1'b0;
        req_a[3*N +: N] = 16'h1234;
        req_b[3*N +: N] = 16'h0FFF;
        req_add_n[3]    = 1'b0;
        req_a[0*N +: N] = 16'h0100;
        req_b[0*N +: N] = 16'h0200;
        req_add_n[0]    = 1'b1;
        req_valid = 4'b1001;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check_val("bp_seen", 32'(got), 32'd1);
        bp_id   = rsp_id;
        bp_sum  = rsp_sum;
        bp_cout = rsp_cout;
        check_val("bp_id", 32'(bp_id), 32'd3);
        check_val("bp_sum", 32'(bp_sum), 32'h2233);
        repeat (5) begin
            @(negedge clk);
            #1;
            check_val("bp_hold_vld", 32'(rsp_valid), 32'd1);
            check_val("bp_hold_id", 32'(rsp_id), 32'(bp_id));
            check_val("bp_hold_sum", 32'(rsp_sum), 32'(bp_sum));
            check_val("bp_hold_cout", 32'(rsp_cout), 32'(bp_cout));
            check_val("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check_val("bp_deliver", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        check_val("bp_after_vld", 32'(rsp_valid), 32'd0);
        check_val("bp_next_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);

        // Reset while the op is in CALC.
        req_a[1*N +: N] = 16'h00AA;
        req_b[1*N +: N] = 16'h0055;
        req_add_n[1]    = 1'b0;
        req_valid = 4'b0010;
        #1;
        check_val("rc_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rc_vld", 32'(rsp_valid), 32'd0);
        n0 = nresp;
        repeat (4) @(negedge clk);
        check_val("rc_no_rsp", 32'(nresp), 32'(n0));
        req_valid = 4'b1111;
        #1;
        check_val("rc_next_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        check_val("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
